jtag_tap_driver: RTL

//  Initiator side of the JTAG user-chain interface. It runs on the system clock and generates jtck/jtms/jtdi toward
//  a TAP, then captures jtdo. One command performs one complete IR or DR scan, starting and ending in Run-Test/Idle.
//  Its uses are board-level test and simulation of the user data-register chains, which shift LSB first.

---
 rtl/jtag_tap_driver.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/jtag_tap_driver.sv
// jtag_tap_driver: system-clock JTAG initiator. One command performs one complete
// IR or DR scan (optionally prefixed by a Test-Logic-Reset sequence), starting and
// ending in Run-Test/Idle. Data shifts LSB first.
// Ports:
//   clock_i, reset_i         system clock, async active-high reset
//   start_i                  one-cycle command strobe, sampled only while idle
//   ir_scan_i, tap_reset_i   scan type and TLR-prefix request, latched at start
//   length_i, tdi_data_i     scan length (clamped to MAX_LEN) and data, latched at start
//   busy_o, done_o           command in progress / one-cycle completion pulse
//   tdo_data_o               captured TDO bits, right-aligned
//   jtck_o, jtms_o, jtdi_o   JTAG signals toward the TAP; jtdo_i from the TAP
module jtag_tap_driver #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               ir_scan_i,
  input  logic               tap_reset_i,
  input  logic [5:0]         length_i,
  input  logic [MAX_LEN-1:0] tdi_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [MAX_LEN-1:0] tdo_data_o,
  output logic               jtck_o,
  output logic               jtms_o,
  output logic               jtdi_o,
  input  logic               jtdo_i
);

  localparam int unsigned LEN_W = 6;
  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_TLR, S_SEL, S_CAP, S_SHIFT, S_UPD, S_FIN
  } state_e;

  state_e             state_q;
  logic [LEN_W-1:0]   bit_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ir_q;
  logic [LEN_W-1:0]   last_q;
  logic [MAX_LEN-1:0] tdi_q;
  logic               tap_unknown_q;
  logic               busy_q;
  logic               done_q;
  logic [MAX_LEN-1:0] tdo_q;
  logic               jtck_q;
  logic               jtms_q;
  logic               jtdi_q;

  state_e             nxt_state_d;
  logic [LEN_W-1:0]   nxt_bit_d;
  logic               scan_end_d;
  logic               jtms_d;
  logic               jtdi_d;

  logic [LEN_W-1:0]   len_c;
  logic [MAX_LEN-1:0] keep_c;
  logic               tick_c;

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tdo_data_o = tdo_q;
  assign jtck_o     = jtck_q;
  assign jtms_o     = jtms_q;
  assign jtdi_o     = jtdi_q;

  // Requested length clamped to the supported width; mask keeps only bits below it.
  assign len_c  = (length_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length_i;
  assign tick_c = (cnt_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    keep_c = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      keep_c[i] = (i < 32'(len_c));
    end
  end

  // Next TCK bit position and the jtms/jtdi values to launch for it.
  always_comb begin
    nxt_state_d = state_q;
    nxt_bit_d   = bit_q + LEN_W'(1);
    scan_end_d  = 1'b0;
    jtms_d      = 1'b0;
    jtdi_d      = 1'b0;
    case (state_q)
      S_TLR: begin
        if (bit_q == LEN_W'(5)) begin
          nxt_state_d = S_SEL;
          nxt_bit_d   = '0;
        end
      end
      S_SEL: begin
        if (!ir_q || bit_q == LEN_W'(1)) begin
          nxt_state_d = S_CAP;
          nxt_bit_d   = '0;
        end
      end
      S_CAP: begin
        if (bit_q == LEN_W'(1)) begin
          nxt_state_d = S_SHIFT;
          nxt_bit_d   = '0;
        end
      end
      S_SHIFT: begin
        if (bit_q == last_q) begin
          nxt_state_d = S_UPD;
          nxt_bit_d   = '0;
        end
      end
      S_UPD: begin
        if (bit_q == LEN_W'(1)) begin
          nxt_state_d = S_IDLE;
          nxt_bit_d   = '0;
          scan_end_d  = 1'b1;
        end
      end
      default: begin
        nxt_state_d = S_IDLE;
        nxt_bit_d   = '0;
      end
    endcase
    case (nxt_state_d)
      S_TLR:   jtms_d = (nxt_bit_d != LEN_W'(5));
      S_SEL:   jtms_d = 1'b1;
      S_SHIFT: begin
        jtms_d = (nxt_bit_d == last_q);
        jtdi_d = tdi_q[IDX_W'(nxt_bit_d)];
      end
      S_UPD:   jtms_d = (nxt_bit_d == '0);
      default: ;
    endcase
  end

  // Sequencer: jtms/jtdi launch on jtck fall (and at start), jtdo sampled on jtck rise.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      bit_q         <= '0;
      cnt_q         <= '0;
      ir_q          <= 1'b0;
      last_q        <= '0;
      tdi_q         <= '0;
      tap_unknown_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tdo_q         <= '0;
      jtck_q        <= 1'b0;
      jtms_q        <= 1'b1;
      jtdi_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (len_c == '0) begin
              state_q <= S_FIN;
            end else begin
              state_q <= (tap_reset_i || tap_unknown_q) ? S_TLR : S_SEL;
              bit_q   <= '0;
              cnt_q   <= '0;
              ir_q    <= ir_scan_i;
              last_q  <= len_c - LEN_W'(1);
              tdi_q   <= tdi_data_i;
              tdo_q   <= tdo_q & keep_c;
              // First bit of both TLR and SEL drives jtms high.
              jtms_q  <= 1'b1;
              jtdi_q  <= 1'b0;
            end
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          if (tick_c) begin
            cnt_q  <= '0;
            jtck_q <= !jtck_q;
            if (!jtck_q) begin
              if (state_q == S_SHIFT) tdo_q[IDX_W'(bit_q)] <= jtdo_i;
            end else begin
              state_q <= nxt_state_d;
              bit_q   <= nxt_bit_d;
              jtms_q  <= jtms_d;
              jtdi_q  <= jtdi_d;
              if (state_q == S_TLR && nxt_state_d == S_SEL) tap_unknown_q <= 1'b0;
              if (scan_end_d) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
